// File: rtl/seq_divider_4_bit.sv
// seq_divider_4_bit
// Iterative restoring divider: an 8-bit dividend over a 4-bit divisor gives
// an 8-bit quotient and a 4-bit remainder. One quotient bit is produced per
// clock. The start/busy/done handshake matches the neighbouring multiplier.
// A zero divisor skips the iterations and reports div_zero with an
// all-ones quotient.

module seq_divider_4_bit #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    // One extra bit so that the terminal count DVD_W-1 never wraps.
    localparam int CNT_W = $clog2(DVD_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    // Partial remainder. After every restore it is below the divisor, so
    // its top bit would always be zero. Only the trial value needs the
    // extra bit.
    logic [DVS_W-1:0]   rem_r;
    logic [DVS_W-1:0]   rem_nxt_s;
    logic [DVD_W-1:0]   q_r;
    logic [DVD_W-1:0]   q_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [DVS_W-1:0]   dvs_r;
    logic [DVS_W-1:0]   dvs_nxt_s;

    logic [DVD_W-1:0]   quotient_r;
    logic [DVD_W-1:0]   quotient_nxt_s;
    logic [DVS_W-1:0]   remainder_r;
    logic [DVS_W-1:0]   remainder_nxt_s;
    logic               div_zero_r;
    logic               div_zero_nxt_s;
    logic               busy_r;
    logic               done_r;

    logic [DVS_W:0]     trial_s;
    logic               fits_s;
    logic [DVS_W-1:0]   diff_s;

    // Trial subtraction for the current iteration: shift in the next dividend bit.
    always_comb begin
        trial_s = {rem_r, q_r[DVD_W-1]};
        fits_s  = (trial_s >= {1'b0, dvs_r});
        diff_s  = DVS_W'(trial_s - {1'b0, dvs_r});
    end

    // Next-state and next-datapath logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        rem_nxt_s       = rem_r;
        q_nxt_s         = q_r;
        cnt_nxt_s       = cnt_r;
        dvs_nxt_s       = dvs_r;
        quotient_nxt_s  = quotient_r;
        remainder_nxt_s = remainder_r;
        div_zero_nxt_s  = div_zero_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (divisor != {DVS_W{1'b0}}) begin
                        q_nxt_s     = dividend;
                        rem_nxt_s   = {DVS_W{1'b0}};
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        dvs_nxt_s   = divisor;
                        state_nxt_s = ST_CALC;
                    end else begin
                        quotient_nxt_s  = {DVD_W{1'b1}};
                        remainder_nxt_s = {DVS_W{1'b0}};
                        div_zero_nxt_s  = 1'b1;
                        state_nxt_s     = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                q_nxt_s   = {q_r[DVD_W-2:0], fits_s};
                rem_nxt_s = fits_s ? diff_s : trial_s[DVS_W-1:0];
                cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(DVD_W - 1)) begin
                    quotient_nxt_s  = {q_r[DVD_W-2:0], fits_s};
                    remainder_nxt_s = fits_s ? diff_s : trial_s[DVS_W-1:0];
                    div_zero_nxt_s  = 1'b0;
                    state_nxt_s     = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset wins over any transition, including a concurrent start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered outputs; busy/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r       <= {DVS_W{1'b0}};
            q_r         <= {DVD_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            dvs_r       <= {DVS_W{1'b0}};
            quotient_r  <= {DVD_W{1'b0}};
            remainder_r <= {DVS_W{1'b0}};
            div_zero_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            rem_r       <= rem_nxt_s;
            q_r         <= q_nxt_s;
            cnt_r       <= cnt_nxt_s;
            dvs_r       <= dvs_nxt_s;
            quotient_r  <= quotient_nxt_s;
            remainder_r <= remainder_nxt_s;
            div_zero_r  <= div_zero_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_DONE);
        end
    end

    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_seq_divider_4_bit.sv
// tb_seq_divider_4_bit
// Scenario tasks for the sequential divider. Expected results come from
// plain integer division (/ and %). A divide by zero is expected to give
// 255 r0 with div_zero set.

module tb_seq_divider_4_bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_zero;

    int tests;
    int failed;

    // Results returned by do_div.
    int         o_lat;
    logic [7:0] o_q;
    logic [3:0] o_r;
    logic       o_dz;
    logic       o_one;
    logic       o_busy_ok;

    seq_divider_4_bit #(.DVD_W(8), .DVS_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request. Report the done latency in cycles after the
    // accepting edge, the result, whether done lasted one cycle, and
    // whether busy stayed high until done.
    task automatic do_div(input logic [7:0] dvd, input logic [3:0] dvs);
        int c;
        @(negedge clk);
        start = 1'b1; dividend = dvd; divisor = dvs;
        @(posedge clk); #1;
        start = 1'b0;
        o_lat = -1; o_q = 8'd0; o_r = 4'd0; o_dz = 1'b0; o_one = 1'b0; o_busy_ok = 1'b1;
        c = 0;
        while (c <= 20) begin
            if (done) begin
                o_lat = c; o_q = quotient; o_r = remainder; o_dz = div_zero;
                break;
            end
            if (!busy) o_busy_ok = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        if (o_lat >= 0) begin
            @(posedge clk); #1;
            o_one = !done && !busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({quotient, remainder, busy, done, div_zero} !== 15'd0) begin
            failed++;
            $display("FAIL reset_outputs got q=%0d r=%0d b=%0b d=%0b z=%0b want all 0",
                     quotient, remainder, busy, done, div_zero);
        end
        rst = 1'b0;
    endtask

    // 36/6 then 35/5 with start held high; the second is accepted on the first IDLE edge.
    task automatic test_back_to_back();
        int c;
        int lat2;
        @(negedge clk);
        start = 1'b1; dividend = 8'd36; divisor = 4'd6;
        @(posedge clk); #1;
        dividend = 8'd35; divisor = 4'd5;
        c = 0;
        while (c <= 20 && !done) begin @(posedge clk); #1; c++; end
        tests++;
        if (c !== 8) begin failed++; $display("FAIL b2b_latency1 got %0d want 8", c); end
        tests++;
        if (quotient !== 8'd6 || remainder !== 4'd0) begin
            failed++; $display("FAIL b2b_result1 got %0d r%0d want 6 r0", quotient, remainder);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin failed++; $display("FAIL b2b_done_width got %0b want 0", done); end
        lat2 = 1;
        while (lat2 <= 20 && !done) begin @(posedge clk); #1; lat2++; end
        start = 1'b0;
        tests++;
        if (lat2 !== 10) begin failed++; $display("FAIL b2b_period got %0d want 10", lat2); end
        tests++;
        if (quotient !== 8'd7 || remainder !== 4'd0 || div_zero !== 1'b0) begin
            failed++; $display("FAIL b2b_result2 got %0d r%0d z%0b want 7 r0 z0", quotient, remainder, div_zero);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin failed++; $display("FAIL b2b_no_third got busy=%0b want 0", busy); end
    endtask

    task automatic test_div_zero();
        do_div(8'd13, 4'd0);
        tests++;
        if (o_lat !== 0 || o_dz !== 1'b1 || o_q !== 8'd255 || o_r !== 4'd0 || o_one !== 1'b1) begin
            failed++;
            $display("FAIL div0 got lat=%0d z=%0b q=%0d r=%0d one=%0b want lat=0 z=1 q=255 r=0 one=1",
                     o_lat, o_dz, o_q, o_r, o_one);
        end
        do_div(8'd14, 4'd2);
        tests++;
        if (o_lat !== 8 || o_dz !== 1'b0 || o_q !== 8'd7 || o_r !== 4'd0) begin
            failed++;
            $display("FAIL div0_recover got lat=%0d z=%0b q=%0d r=%0d want lat=8 z=0 q=7 r=0",
                     o_lat, o_dz, o_q, o_r);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] dv [4];
        logic [3:0] ds [4];
        dv[0] = 8'd255; ds[0] = 4'd1;
        dv[1] = 8'd5;   ds[1] = 4'd9;
        dv[2] = 8'd0;   ds[2] = 4'd3;
        dv[3] = 8'd200; ds[3] = 4'd7;
        for (int i = 0; i < 4; i++) begin
            do_div(dv[i], ds[i]);
            tests++;
            if (o_lat !== 8 || o_q !== 8'(dv[i] / ds[i]) || o_r !== 4'(dv[i] % ds[i]) ||
                o_dz !== 1'b0 || o_one !== 1'b1 || o_busy_ok !== 1'b1) begin
                failed++;
                $display("FAIL boundary_%0d_%0d got lat=%0d q=%0d r=%0d z=%0b one=%0b busy_ok=%0b want lat=8 q=%0d r=%0d",
                         dv[i], ds[i], o_lat, o_q, o_r, o_dz, o_one, o_busy_ok,
                         dv[i] / ds[i], dv[i] % ds[i]);
            end
        end
    endtask

    // 49/7 with a second start and new operand pins two cycles in; runs after 200/7 = 28 r4.
    task automatic test_ignore_inputs();
        int  c;
        logic busy_ok;
        logic hold_ok;
        busy_ok = 1'b1; hold_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; dividend = 8'd49; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (c <= 20 && !done) begin
            if (!busy) busy_ok = 1'b0;
            if (quotient !== 8'd28 || remainder !== 4'd4) hold_ok = 1'b0;
            if (c == 2) begin start = 1'b1; dividend = 8'd100; divisor = 4'd3; end
            if (c == 3) start = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        tests++;
        if (busy_ok !== 1'b1) begin failed++; $display("FAIL ign_busy got gap want continuous"); end
        tests++;
        if (hold_ok !== 1'b1) begin failed++; $display("FAIL ign_hold got cleared want 28 r4 held"); end
        tests++;
        if (c !== 8 || quotient !== 8'd7 || remainder !== 4'd0) begin
            failed++; $display("FAIL ign_result got lat=%0d q=%0d r=%0d want lat=8 q=7 r=0", c, quotient, remainder);
        end
        c = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (busy || done) c++;
        end
        tests++;
        if (c !== 0) begin failed++; $display("FAIL ign_not_queued got %0d busy cycles want 0", c); end
    endtask

    // Reset in the 4th CALC cycle of 200/7 abandons it; a reset with a concurrent start wins too.
    task automatic test_reset_mid_op();
        int c;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({quotient, remainder, busy, done, div_zero} !== 15'd0) begin
            failed++;
            $display("FAIL rst_mid_outputs got q=%0d r=%0d b=%0b d=%0b z=%0b want all 0",
                     quotient, remainder, busy, done, div_zero);
        end
        c = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) c++;
        end
        tests++;
        if (c !== 0) begin failed++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", c); end
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = 8'd50; divisor = 4'd5;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin failed++; $display("FAIL rst_vs_start got busy=%0b want 0", busy); end
        do_div(8'd9, 4'd2);
        tests++;
        if (o_lat !== 8 || o_q !== 8'd4 || o_r !== 4'd1) begin
            failed++; $display("FAIL rst_recover got lat=%0d q=%0d r=%0d want lat=8 q=4 r=1", o_lat, o_q, o_r);
        end
    endtask

    // Every dividend with every nonzero divisor, in shuffled order.
    task automatic test_sweep();
        int pairs [3840];
        int j, tmp, dvd, dvs;
        for (int i = 0; i < 3840; i++) pairs[i] = i;
        for (int i = 3839; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = pairs[i]; pairs[i] = pairs[j]; pairs[j] = tmp;
        end
        for (int i = 0; i < 3840; i++) begin
            dvd = pairs[i] / 15;
            dvs = (pairs[i] % 15) + 1;
            do_div(8'(dvd), 4'(dvs));
            tests++;
            if (o_lat !== 8 || int'(o_q) * dvs + int'(o_r) != dvd || int'(o_r) >= dvs ||
                int'(o_q) != dvd / dvs || o_dz !== 1'b0 || o_one !== 1'b1 || o_busy_ok !== 1'b1) begin
                failed++;
                $display("FAIL sweep_%0d_%0d got lat=%0d q=%0d r=%0d z=%0b one=%0b want lat=8 q=%0d r=%0d",
                         dvd, dvs, o_lat, o_q, o_r, o_dz, o_one, dvd / dvs, dvd % dvs);
            end
        end
    endtask

    initial begin
        tests = 0; failed = 0;
        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        test_reset();
        test_back_to_back();
        test_div_zero();
        test_boundaries();
        test_ignore_inputs();
        test_reset_mid_op();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
